// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage pipeline.
//
// Owns the program counter and the IF/ID pipeline register. Each cycle the
// PC is driven to instruction memory. The word that comes back
// (asynchronous read) is captured into IF/ID together with its PC.
//
// Control inputs, in priority order while running:
//   redirect_i > stall_i > normal sequential fetch.
// When the fetched word is the halt encoding, the stage also stops
// fetching on its own.
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset
//   stall_i        in   hold PC and IF/ID (load-use hazard)
//   redirect_i     in   control transfer from EX: flush IF/ID, load PC
//   redirect_pc_i  in   redirect target byte address (low 2 bits ignored)
//   imem_addr_o    out  instruction-memory address (= pc, combinational)
//   imem_rdata_i   in   instruction word, valid in the same cycle
//   if_pc_o        out  IF/ID.Curr_Pc
//   if_instr_o     out  IF/ID.Curr_Instr
//   if_valid_o     out  IF/ID holds a real instruction (0 = bubble)
//   halted_o       out  fetch stopped on the halt instruction
//   fetch_cnt_o    out  saturating count of instructions captured
// ---------------------------------------------------------------------------
module if_stage #(
  parameter int                  PC_W       = 9,
  parameter int                  INSTR_W    = 32,
  parameter logic [PC_W-1:0]     RESET_PC   = 9'h000,
  parameter logic [INSTR_W-1:0]  NOP_INSTR  = 32'h0000_0013,
  parameter logic [INSTR_W-1:0]  HALT_INSTR = 32'h0010_0073
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  output logic [PC_W-1:0]    if_pc_o,
  output logic [INSTR_W-1:0] if_instr_o,
  output logic               if_valid_o,
  output logic               halted_o,
  output logic [31:0]        fetch_cnt_o
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t             state_r, next_state_s;
  logic [PC_W-1:0]    pc_r, next_pc_s;
  logic [PC_W-1:0]    next_if_pc_s;
  logic [INSTR_W-1:0] next_if_instr_s;
  logic               next_if_valid_s;
  logic               next_halted_s;
  logic [31:0]        next_cnt_s;
  logic [PC_W-1:0]    redirect_aligned_s;
  logic [31:0]        cnt_inc_s;

  // Redirect targets are word-aligned by clearing the two low bits.
  assign redirect_aligned_s = {redirect_pc_i[PC_W-1:2], 2'b00};

  // The fetch counter saturates at all-ones instead of wrapping.
  assign cnt_inc_s = (fetch_cnt_o == 32'hFFFF_FFFF) ? fetch_cnt_o
                                                    : fetch_cnt_o + 32'd1;

  assign imem_addr_o = pc_r;

  // Next-state and next-register computation for PC, IF/ID and the counter.
  always_comb begin
    next_state_s    = state_r;
    next_pc_s       = pc_r;
    next_if_pc_s    = if_pc_o;
    next_if_instr_s = if_instr_o;
    next_if_valid_s = if_valid_o;
    next_halted_s   = halted_o;
    next_cnt_s      = fetch_cnt_o;

    case (state_r)
      BOOT: begin
        // One idle cycle. The inputs are ignored and IF/ID stays a bubble.
        next_if_pc_s    = {PC_W{1'b0}};
        next_if_instr_s = NOP_INSTR;
        next_if_valid_s = 1'b0;
        next_state_s    = RUN;
      end
      RUN: begin
        if (redirect_i) begin
          next_pc_s       = redirect_aligned_s;
          next_if_pc_s    = {PC_W{1'b0}};
          next_if_instr_s = NOP_INSTR;
          next_if_valid_s = 1'b0;
        end else if (stall_i) begin
          next_pc_s = pc_r;
        end else begin
          next_if_pc_s    = pc_r;
          next_if_instr_s = imem_rdata_i;
          next_if_valid_s = 1'b1;
          next_cnt_s      = cnt_inc_s;
          if (imem_rdata_i == HALT_INSTR) begin
            // The PC is left on the halt word, so the fetch address freezes there.
            next_halted_s = 1'b1;
            next_state_s  = HALT;
          end else begin
            next_pc_s = pc_r + 9'd4;
          end
        end
      end
      HALT: begin
        // IF/ID drains to a bubble. Only a redirect, which comes from an
        // older branch and means the halt was on the wrong path, restarts
        // fetch.
        next_if_pc_s    = {PC_W{1'b0}};
        next_if_instr_s = NOP_INSTR;
        next_if_valid_s = 1'b0;
        if (redirect_i) begin
          next_pc_s     = redirect_aligned_s;
          next_halted_s = 1'b0;
          next_state_s  = RUN;
        end else begin
          next_pc_s = pc_r;
        end
      end
      default: begin
        next_state_s    = BOOT;
        next_pc_s       = RESET_PC;
        next_if_pc_s    = {PC_W{1'b0}};
        next_if_instr_s = NOP_INSTR;
        next_if_valid_s = 1'b0;
        next_halted_s   = 1'b0;
      end
    endcase
  end

  // Register all state and outputs. Reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= BOOT;
      pc_r        <= RESET_PC;
      if_pc_o     <= {PC_W{1'b0}};
      if_instr_o  <= NOP_INSTR;
      if_valid_o  <= 1'b0;
      halted_o    <= 1'b0;
      fetch_cnt_o <= 32'd0;
    end else begin
      state_r     <= next_state_s;
      pc_r        <= next_pc_s;
      if_pc_o     <= next_if_pc_s;
      if_instr_o  <= next_if_instr_s;
      if_valid_o  <= next_if_valid_s;
      halted_o    <= next_halted_s;
      fetch_cnt_o <= next_cnt_s;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- directed, self-checking bench for if_stage.
// The instruction memory returns 0xA000_0000 | addr. It can optionally
// return the halt word at one chosen address.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [8:0]  if_pc;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        halted;
  logic [31:0] fetch_cnt;

  logic        halt_en;
  logic [8:0]  halt_addr;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] HLT  = 32'h0010_0073;
  localparam logic [31:0] TAG  = 32'hA000_0000;

  always #5 clk = ~clk;

  assign imem_rdata = (halt_en && imem_addr == halt_addr) ? HLT
                                                          : (TAG | {23'd0, imem_addr});

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .if_pc_o       (if_pc),
    .if_instr_o    (if_instr),
    .if_valid_o    (if_valid),
    .halted_o      (halted),
    .fetch_cnt_o   (fetch_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full IF/ID and control-output snapshot.
  task automatic check_all(input string tag, input logic [8:0] pc, input logic [31:0] instr,
                           input logic valid, input logic hlt, input logic [31:0] cnt,
                           input logic [8:0] addr);
    check({tag, ".pc"},    {23'd0, if_pc},     {23'd0, pc});
    check({tag, ".instr"}, if_instr,           instr);
    check({tag, ".valid"}, {31'd0, if_valid},  {31'd0, valid});
    check({tag, ".halt"},  {31'd0, halted},    {31'd0, hlt});
    check({tag, ".cnt"},   fetch_cnt,          cnt);
    check({tag, ".addr"},  {23'd0, imem_addr}, {23'd0, addr});
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 9'd0;
    halt_en = 1'b0; halt_addr = 9'h020;
    tick(); tick();
    check_all("rst", 9'h000, NOP, 1'b0, 1'b0, 32'd0, 9'h000);

    // 1: boot bubble, then sequential fetch
    reset = 1'b0;
    tick();
    check_all("boot", 9'h000, NOP, 1'b0, 1'b0, 32'd0, 9'h000);
    tick(); check_all("seq0", 9'h000, 32'hA000_0000, 1'b1, 1'b0, 32'd1, 9'h004);
    tick(); check_all("seq4", 9'h004, 32'hA000_0004, 1'b1, 1'b0, 32'd2, 9'h008);
    tick(); check_all("seq8", 9'h008, 32'hA000_0008, 1'b1, 1'b0, 32'd3, 9'h00C);

    // 2: stall two cycles
    stall = 1'b1;
    tick(); check_all("stall1", 9'h008, 32'hA000_0008, 1'b1, 1'b0, 32'd3, 9'h00C);
    tick(); check_all("stall2", 9'h008, 32'hA000_0008, 1'b1, 1'b0, 32'd3, 9'h00C);
    stall = 1'b0;
    tick(); check_all("resume", 9'h00C, 32'hA000_000C, 1'b1, 1'b0, 32'd4, 9'h010);

    // 3: redirect wins over stall, target low bits cleared
    redirect = 1'b1; redirect_pc = 9'h1A3; stall = 1'b1;
    tick(); check_all("redir", 9'h000, NOP, 1'b0, 1'b0, 32'd4, 9'h1A0);
    redirect = 1'b0; stall = 1'b0;
    tick(); check_all("redir_tgt", 9'h1A0, 32'hA000_01A0, 1'b1, 1'b0, 32'd5, 9'h1A4);

    // 4: PC wrap at the top of the address space
    redirect = 1'b1; redirect_pc = 9'h1FC;
    tick(); check_all("to1fc", 9'h000, NOP, 1'b0, 1'b0, 32'd5, 9'h1FC);
    redirect = 1'b0;
    tick(); check_all("pc1fc", 9'h1FC, 32'hA000_01FC, 1'b1, 1'b0, 32'd6, 9'h000);
    tick(); check_all("wrap", 9'h000, 32'hA000_0000, 1'b1, 1'b0, 32'd7, 9'h004);

    // 5: halt at 0x20; stall ignored while halted; redirect recovers
    halt_en = 1'b1;
    redirect = 1'b1; redirect_pc = 9'h020;
    tick(); check_all("to20", 9'h000, NOP, 1'b0, 1'b0, 32'd7, 9'h020);
    redirect = 1'b0;
    tick(); check_all("halt_cap", 9'h020, HLT, 1'b1, 1'b1, 32'd8, 9'h020);
    stall = 1'b1;
    tick(); check_all("halt_bub", 9'h000, NOP, 1'b0, 1'b1, 32'd8, 9'h020);
    stall = 1'b0;
    tick(); check_all("halt_hold", 9'h000, NOP, 1'b0, 1'b1, 32'd8, 9'h020);
    halt_en = 1'b0;
    redirect = 1'b1; redirect_pc = 9'h040;
    tick(); check_all("unhalt", 9'h000, NOP, 1'b0, 1'b0, 32'd8, 9'h040);
    redirect = 1'b0;
    tick(); check_all("pc40", 9'h040, 32'hA000_0040, 1'b1, 1'b0, 32'd9, 9'h044);

    // 6: reset mid-run (with stall) at pc 0x80
    redirect = 1'b1; redirect_pc = 9'h080;
    tick(); check_all("to80", 9'h000, NOP, 1'b0, 1'b0, 32'd9, 9'h080);
    redirect = 1'b0;
    tick(); check_all("pc80", 9'h080, 32'hA000_0080, 1'b1, 1'b0, 32'd10, 9'h084);
    reset = 1'b1; stall = 1'b1;
    tick(); check_all("rst_mid", 9'h000, NOP, 1'b0, 1'b0, 32'd0, 9'h000);
    reset = 1'b0; stall = 1'b0;
    tick(); check_all("boot2", 9'h000, NOP, 1'b0, 1'b0, 32'd0, 9'h000);
    tick(); check_all("refetch", 9'h000, 32'hA000_0000, 1'b1, 1'b0, 32'd1, 9'h004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction-fetch stage of the 5-stage pipeline; owns the program counter and the IF/ID pipeline register. Each cycle it drives the instruction-memory address, captures the PC and the returned word into IF/ID, and forwards them to decode. Three inputs control it: load-use stall from the hazard unit, redirect (taken branch/jal/jalr) from EX, and a self-detected halt instruction. Its outputs populate the if_id_reg fields Curr_Pc and Curr_Instr.

Parameters:
PC_W, 9, PC / instruction byte-address width (matches Curr_Pc)
INSTR_W, 32, instruction width
RESET_PC, 9'h000, PC value after reset
NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)
HALT_INSTR, 32'h0010_0073, ebreak; stops fetch

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
stall_i  in  1  hold PC and IF/ID (load-use hazard)
redirect_i  in  1  control transfer resolved in EX; flush IF/ID and load PC
redirect_pc_i  in  PC_W  redirect target byte address
imem_addr_o  out  PC_W  instruction-memory address (= pc_q, combinational)
imem_rdata_i  in  INSTR_W  instruction word; asynchronous read, valid same cycle
if_pc_o  out  PC_W  IF/ID.Curr_Pc
if_instr_o  out  INSTR_W  IF/ID.Curr_Instr
if_valid_o  out  1  IF/ID holds a real instruction (0 = bubble)
halted_o  out  1  fetch stopped on HALT_INSTR
fetch_cnt_o  out  32  count of instructions captured into IF/ID

Behaviour:
- Clock clk; reset synchronous active-high, sampled on rising edge; any cycle with reset=1 (incl. mid-operation) applies reset values next edge, overriding all other inputs.
- Reset values: pc_q=RESET_PC, if_pc_o=0, if_instr_o=NOP_INSTR, if_valid_o=0, halted_o=0, fetch_cnt_o=0, state=BOOT.
- imem_addr_o = pc_q always (all states).
- FSM states BOOT, RUN, HALT.
- BOOT: exactly one cycle; IF/ID stays bubble; pc_q unchanged; stall_i/redirect_i ignored; -> RUN.
- RUN, per-cycle priority redirect_i > stall_i > normal:
  - redirect_i=1: pc_q <= {redirect_pc_i[PC_W-1:2],2'b00} (low bits forced 0); IF/ID <= bubble (pc 0, NOP_INSTR, valid 0); counter unchanged; stays RUN.
  - stall_i=1 (no redirect): pc_q, IF/ID, counter hold.
  - normal: IF/ID <= {pc_q, imem_rdata_i, valid 1}; pc_q <= pc_q+4 modulo 2^PC_W (508+4 -> 0); fetch_cnt_o +1, saturating at 32'hFFFF_FFFF.
  - normal capture of imem_rdata_i==HALT_INSTR: captured as valid instruction and counted; pc_q NOT incremented; -> HALT.
- HALT: halted_o=1; IF/ID holds the halt instruction for a cycle then becomes bubble on the next edge; pc_q frozen; stall_i ignored.
  - redirect_i=1 in HALT (older branch, halt was wrong-path): pc_q <= aligned target; IF/ID <= bubble; halted_o <= 0; -> RUN.
- Latency: imem word appears on if_instr_o one cycle after its address is driven.
- All outputs registered except imem_addr_o.

Test Plan:
1. Reset, imem returns addr-tagged words 0xA000_0000|addr, no stall -> BOOT bubble one cycle, then if_pc_o 0,4,8,... on consecutive cycles, valid=1, fetch_cnt_o increments 1 per cycle.
2. stall_i high 2 cycles while IF/ID holds pc 8 -> if_pc_o stays 8, imem_addr_o stays 12, counter frozen; resumes with pc 12 after release.
3. redirect_i with redirect_pc_i=0x1A3 concurrent with stall_i -> next cycle if_valid_o=0, if_instr_o=0x0000_0013; imem_addr_o=0x1A0; following cycle if_pc_o=0x1A0.
4. Sequential fetch from pc 0x1FC -> if_pc_o 0x1FC, then 0x000 (wrap), no X.
5. imem returns 0x0010_0073 at pc 0x20 -> if_instr_o=0x0010_0073 valid one cycle, then bubbles; halted_o=1; imem_addr_o stays 0x20; later redirect to 0x40 -> halted_o=0, fetch resumes at 0x40.
6. reset asserted mid-RUN at pc 0x80 with stall_i=1 -> next cycle all outputs at reset values, BOOT then fetch from 0x000.
